// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM-stage access unit.
// Holds the FSM state encoding, RV32I load/store funct3 codes,
// byte-enable patterns and the request-legality helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Stores only come in byte/half/word; loads add the unsigned variants.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            return funct3 inside {F3_SB, F3_SH, F3_SW};
        end
        return funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half lane out of a raw bus word
// and sign- or zero-extends it according to the load funct3.
module load_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane selection and extension of the raw read word.
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_LBU:  data_o = {24'h0, byte_lane};
            F3_LH:   data_o = {{16{half_lane[15]}}, half_lane};
            F3_LHU:  data_o = {16'h0, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store responder for the RV32I pipeline.
// Issues one single-beat valid/grant bus transaction per access, stalls the
// pipeline until it completes, then hands the writeback triple to MEM/WB.
// Build option: define MEM_MISALIGN_CHK_EN to fault misaligned half/word
// accesses instead of silently ignoring the offending address bits.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    input  logic        rd_wen_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_we_i,
    input  logic        mem_re_i,
    input  logic [2:0]  mem_funct3_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        rd_wen_o,
    output logic        err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              rd_wen_q, rd_wen_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              access_req;
    logic              bad_req;
    logic [3:0]        be_fmt;
    logic [31:0]       wdata_fmt;
    logic [31:0]       load_data;

    assign access_req = mem_we_i | mem_re_i;

    // A request is faulted when its funct3 is undefined (or misaligned, if enabled).
    always_comb begin
        bad_req = !funct3_legal(mem_we_i, mem_funct3_i);
`ifdef MEM_MISALIGN_CHK_EN
        bad_req = bad_req | misaligned(mem_funct3_i, mem_addr_i[1:0]);
`endif
    end

    // Byte enables and lane-replicated write data for the incoming store.
    always_comb begin
        be_fmt    = BE_WORD;
        wdata_fmt = '0;
        if (mem_we_i) begin
            case (mem_funct3_i[1:0])
                2'b00: begin
                    be_fmt    = BE_BYTE << mem_addr_i[1:0];
                    wdata_fmt = {4{mem_data_i[7:0]}};
                end
                2'b01: begin
                    be_fmt    = BE_HALF << {mem_addr_i[1], 1'b0};
                    wdata_fmt = {2{mem_data_i[15:0]}};
                end
                default: begin
                    be_fmt    = BE_WORD;
                    wdata_fmt = mem_data_i;
                end
            endcase
        end
    end

    // Next-state logic for the access FSM and everything it latches.
    always_comb begin
        state_d   = state_q;
        bus_req_d = 1'b0;
        we_d      = we_q;
        addr_d    = addr_q;
        funct3_d  = funct3_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        rd_wen_d  = rd_wen_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (access_req) begin
                    we_d      = mem_we_i;
                    addr_d    = mem_addr_i;
                    funct3_d  = mem_funct3_i;
                    be_d      = be_fmt;
                    wdata_d   = wdata_fmt;
                    rd_addr_d = rd_addr_i;
                    rd_data_d = rd_data_i;
                    rd_wen_d  = rd_wen_i;
                    cnt_d     = '0;
                    if (bad_req) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = ST_REQ;
                        bus_req_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_gnt_i) begin
                    state_d = we_q ? ST_DONE : ST_WAIT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    bus_req_d = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus_rvalid_i) begin
                    rdata_d = bus_rdata_i;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched request registers; reset aborts any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bus_req_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            funct3_q  <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            rd_wen_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bus_req_q <= bus_req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            funct3_q  <= funct3_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            rd_wen_q  <= rd_wen_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    load_align u_load_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .rdata_i   (rdata_q),
        .data_o    (load_data)
    );

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = {addr_q[31:2], 2'b00};
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
    assign err_o       = err_q;
    assign stall_o     = ((state_q == ST_IDLE) & access_req) |
                         (state_q == ST_REQ) | (state_q == ST_WAIT);

    // Writeback: pass-through when idle, latched result on completion, muted otherwise.
    always_comb begin
        rd_addr_o = rd_addr_q;
        rd_data_o = rd_data_q;
        rd_wen_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rd_addr_o = rd_addr_i;
                rd_data_o = rd_data_i;
                rd_wen_o  = rd_wen_i & ~access_req;
            end
            ST_DONE: begin
                rd_data_o = we_q ? rd_data_q : load_data;
                rd_wen_o  = rd_wen_q & ~err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench for mem_access_unit.
// Honours MEM_MISALIGN_CHK_EN in its reference model when defined.
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

`ifdef MEM_MISALIGN_CHK_EN
    localparam bit MisalignChk = 1'b1;
`else
    localparam bit MisalignChk = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        rd_wen_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic        mem_we_i;
    logic        mem_re_i;
    logic [2:0]  mem_funct3_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wen_o;
    logic        err_o;

    typedef struct {
        bit          isErr;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr_i    (rd_addr_i),
        .rd_data_i    (rd_data_i),
        .rd_wen_i     (rd_wen_i),
        .mem_addr_i   (mem_addr_i),
        .mem_data_i   (mem_data_i),
        .mem_we_i     (mem_we_i),
        .mem_re_i     (mem_re_i),
        .mem_funct3_i (mem_funct3_i),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .stall_o      (stall_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .rd_wen_o     (rd_wen_o),
        .err_o        (err_o)
    );

    // Free-running pipeline clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a hung DUT still ends the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference load result from byte arithmetic on the raw word.
    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] raw);
        int lane;
        int val;
        lane = int'(addr % 4);
        case (f3)
            3'd0, 3'd4: begin
                val = int'((raw >> (8 * lane)) & 32'hFF);
                if (f3 == 3'd0 && val >= 128) val = val - 256;
            end
            3'd1, 3'd5: begin
                val = int'((raw >> (16 * ((lane / 2) % 2))) & 32'hFFFF);
                if (f3 == 3'd1 && val >= 32768) val = val - 65536;
            end
            default: val = int'(raw);
        endcase
        return 32'(val);
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] addr);
        int lane;
        lane = int'(addr % 4);
        if (f3 == 3'd0) return 4'(1 << lane);
        if (f3 == 3'd1) return 4'(3 << (2 * (lane / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] data);
        if (f3 == 3'd0) return (data & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1) return (data & 32'hFFFF) * 32'h00010001;
        return data;
    endfunction

    // Scoreboard monitor: every writeback or fault pulse consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (err_o) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected err: got err_o=1 required no event");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("event is fault", 32'(err_o), 32'(e.isErr));
                    checkOutput("fault wen", 32'(rd_wen_o), 32'd0);
                end
            end else if (rd_wen_o && !stall_o) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected wb: got rd=%0d data=0x%08h required no event", rd_addr_o, rd_data_o);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("event is fault", 32'(err_o), 32'(e.isErr));
                    checkOutput("wb rd addr", 32'(rd_addr_o), 32'(e.addr));
                    checkOutput("wb rd data", rd_data_o, e.data);
                end
            end
        end
    end

    // kind: 0 non-memory, 1 load, 2 store. Enters and leaves just after a rising edge.
    task automatic applyStimulus(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] rdataIn,
                                 input logic [4:0] rdA, input logic [31:0] rdD, input bit rdW,
                                 input int gd, input int rvd, input bit noResp);
        bit   isLoad, isStore, legal, mis, isFault, timeout;
        int   sizeBytes, expStalls, expReq, stalls, reqCycles, waitCycles;
        bit   granted, finished;
        exp_t e;

        isLoad  = (kind == 1);
        isStore = (kind == 2);
        legal   = isStore ? (f3 <= 3'd2) : (isLoad ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : 1'b1);
        sizeBytes = (f3[1:0] == 2'b01) ? 2 : ((f3[1:0] == 2'b10) ? 4 : 1);
        mis     = MisalignChk && (addr % sizeBytes != 0);
        isFault = (isLoad || isStore) && (!legal || mis);
        timeout = !isFault && (isLoad || isStore) && noResp;

        if (!(isLoad || isStore)) begin
            expStalls = 0; expReq = 0;
        end else if (isFault) begin
            expStalls = 1; expReq = 0;
        end else if (timeout) begin
            expStalls = 1 + TIMEOUT; expReq = isStore ? TIMEOUT : gd + 1;
        end else begin
            expStalls = 1 + (gd + 1) + (isLoad ? rvd + 1 : 0); expReq = gd + 1;
        end

        if (isFault || timeout) begin
            e.isErr = 1'b1; e.addr = '0; e.data = '0;
            expQ.push_back(e);
        end else if (rdW) begin
            e.isErr = 1'b0; e.addr = rdA;
            e.data  = isLoad ? modelLoad(f3, addr, rdataIn) : rdD;
            expQ.push_back(e);
        end

        rd_addr_i    = rdA;
        rd_data_i    = rdD;
        rd_wen_i     = rdW;
        mem_addr_i   = addr;
        mem_data_i   = sdata;
        mem_funct3_i = f3;
        mem_we_i     = isStore;
        mem_re_i     = isLoad;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;

        stalls = 0; reqCycles = 0; waitCycles = 0; granted = 0; finished = 0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            #1;
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b0;
            if (!stall_o) begin
                finished = 1;
            end else begin
                stalls++;
                if (bus_req_o) begin
                    checkOutput("bus addr", bus_addr_o, {addr[31:2], 2'b00});
                    checkOutput("bus we", 32'(bus_we_o), 32'(isStore));
                    if (isStore) begin
                        checkOutput("bus be", 32'(bus_be_o), 32'(modelBe(f3, addr)));
                        checkOutput("bus wdata", bus_wdata_o, modelWdata(f3, sdata));
                    end
                    if (!(isStore && noResp) && reqCycles == gd) begin
                        bus_gnt_i = 1'b1;
                        granted   = 1'b1;
                    end else if ($urandom_range(0, 3) == 0) begin
                        bus_rvalid_i = 1'b1;
                        bus_rdata_i  = ~rdataIn;
                    end
                    reqCycles++;
                end else if (granted && isLoad) begin
                    if (!noResp && waitCycles == rvd) begin
                        bus_rvalid_i = 1'b1;
                        bus_rdata_i  = rdataIn;
                    end
                    waitCycles++;
                end
                @(posedge clk);
                #1;
            end
        end
        if (!finished) begin
            checkCount++;
            $display("[TB] FAIL stall bound: got stall_o still high after 200 cycles required release");
        end
        checkOutput("stall cycles", 32'(stalls), 32'(expStalls));
        checkOutput("req cycles", 32'(reqCycles), 32'(expReq));
        @(posedge clk);
        #1;
    endtask

    task automatic randomOp();
        int         kind;
        logic [2:0] f3;
        logic [2:0] loadCodes [5];
        loadCodes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        kind = $urandom_range(0, 9);
        if (kind <= 2) begin
            kind = 0; f3 = 3'($urandom);
        end else if (kind <= 5) begin
            kind = 1; f3 = loadCodes[$urandom_range(0, 4)];
        end else if (kind <= 8) begin
            kind = 2; f3 = 3'($urandom_range(0, 2));
        end else begin
            kind = $urandom_range(1, 2); f3 = 3'($urandom);
        end
        applyStimulus(kind, f3, $urandom, $urandom, $urandom, 5'($urandom), $urandom,
                      1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5),
                      ($urandom_range(0, 14) == 0));
    endtask

    // Abort a load in REQ with reset; a late response must be discarded.
    task automatic resetMidTransaction();
        rd_addr_i = 5'd9; rd_data_i = 32'h0; rd_wen_i = 1'b1;
        mem_addr_i = 32'h0000_0400; mem_funct3_i = 3'd2; mem_we_i = 1'b0; mem_re_i = 1'b1;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        #1;
        checkOutput("abort idle stall", 32'(stall_o), 32'd1);
        @(posedge clk);
        #2;
        checkOutput("abort req up", 32'(bus_req_o), 32'd1);
        mem_re_i = 1'b0; rd_wen_i = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("abort req async drop", 32'(bus_req_o), 32'd0);
        checkOutput("abort stall drop", 32'(stall_o), 32'd0);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hDEAD_BEEF;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus_rvalid_i = 1'b0;
        checkOutput("abort stays idle", 32'(stall_o), 32'd0);
        checkOutput("abort no req", 32'(bus_req_o), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        rd_addr_i = 5'd5; rd_data_i = 32'h1234; rd_wen_i = 1'b1;
        mem_addr_i = '0; mem_data_i = '0; mem_we_i = 1'b0; mem_re_i = 1'b0; mem_funct3_i = '0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        #12;
        checkOutput("reset bus_req", 32'(bus_req_o), 32'd0);
        checkOutput("reset bus_we", 32'(bus_we_o), 32'd0);
        checkOutput("reset bus_be", 32'(bus_be_o), 32'd0);
        checkOutput("reset bus_addr", bus_addr_o, 32'd0);
        checkOutput("reset bus_wdata", bus_wdata_o, 32'd0);
        checkOutput("reset err", 32'(err_o), 32'd0);
        checkOutput("reset stall", 32'(stall_o), 32'd0);
        checkOutput("reset passthru data", rd_data_o, 32'h1234);
        checkOutput("reset passthru wen", 32'(rd_wen_o), 32'd1);
        #11;
        rst = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd5, 32'h1234, 1'b1, 0, 0, 1'b0);
        applyStimulus(2, 3'd0, 32'h103, 32'hAB, 32'h0, 5'd0, 32'h55, 1'b1, 0, 0, 1'b0);
        applyStimulus(1, 3'd0, 32'h202, 32'h0, 32'h0080_0000, 5'd7, 32'h0, 1'b1, 0, 0, 1'b0);
        applyStimulus(1, 3'd4, 32'h202, 32'h0, 32'h0080_0000, 5'd8, 32'h0, 1'b1, 0, 0, 1'b0);
        applyStimulus(1, 3'd1, 32'h206, 32'h0, 32'h9ABC_1234, 5'd3, 32'h0, 1'b1, 1, 1, 1'b0);
        applyStimulus(1, 3'd2, 32'h200, 32'h0, 32'hCAFE_F00D, 5'd10, 32'h0, 1'b1, 3, 0, 1'b0);
        applyStimulus(2, 3'd1, 32'h302, 32'hBEEF, 32'h0, 5'd0, 32'h0, 1'b0, 2, 0, 1'b0);
        applyStimulus(1, 3'd2, 32'h300, 32'h0, 32'h0, 5'd11, 32'h0, 1'b1, 1, 0, 1'b1);
        applyStimulus(2, 3'd2, 32'h300, 32'h1, 32'h0, 5'd0, 32'h0, 1'b1, 0, 0, 1'b1);
        applyStimulus(1, 3'd3, 32'h100, 32'h0, 32'h0, 5'd12, 32'h0, 1'b1, 0, 0, 1'b0);
        applyStimulus(2, 3'd4, 32'h100, 32'h0, 32'h0, 5'd12, 32'h0, 1'b1, 0, 0, 1'b0);
        applyStimulus(1, 3'd2, 32'h101, 32'h0, 32'h1122_3344, 5'd13, 32'h0, 1'b1, 0, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            randomOp();
        end
        resetMidTransaction();
        for (int i = 0; i < 20; i++) begin
            randomOp();
        end

        mem_we_i = 1'b0; mem_re_i = 1'b0; rd_wen_i = 1'b0;
        repeat (2) @(posedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
